// File: rtl/dinv_scale_pkg.sv
// Shared types and Q4.12 arithmetic constants for the diagonal-inverse scaler.
package dinv_scale_pkg;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_SCALE = 1'b1
  } state_e;

  localparam int unsigned FRAC_BITS   = 12;
  localparam int unsigned ROUND_CONST = 2048;

endpackage

// File: rtl/dinv_scale_if.sv
// Diagonal load, y-input and z-output handshake bundle of the scaler.
interface dinv_scale_if #(
  parameter int unsigned W = 16
);
  logic         en;
  logic         reload;
  logic [W-1:0] d_in;
  logic         d_flag;
  logic [W-1:0] y_in;
  logic         y_valid;
  logic         y_ready;
  logic [W-1:0] z_out;
  logic         z_valid;
  logic         z_ready;
  logic         z_last;
  logic         load_done;
  logic         sat_flag;

  modport master (
    output en, reload, d_in, d_flag, y_in, y_valid, z_ready,
    input  y_ready, z_out, z_valid, z_last, load_done, sat_flag
  );

  modport slave (
    input  en, reload, d_in, d_flag, y_in, y_valid, z_ready,
    output y_ready, z_out, z_valid, z_last, load_done, sat_flag
  );
endinterface

// File: rtl/dinv_scale_q412_round_sat.sv
// Rounds a Q8.24-scaled product back to Q4.12 (half up) and saturates to W bits.
module q412_round_sat
  import dinv_scale_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic signed [2*W:0] prod_i,
  output logic [W-1:0]        z_c_o,
  output logic                sat_c_o
);
  localparam int unsigned PW = 2 * W + 1;
  localparam int unsigned SW = PW + 1 - FRAC_BITS;

  logic signed [PW:0] sum_c;
  logic [SW-1:0]      shr_c;
  logic               pos_c;

  // One guard bit keeps the rounding add from wrapping at the positive extreme.
  always_comb begin
    sum_c   = $signed({prod_i[PW-1], prod_i}) + $signed((PW + 1)'(ROUND_CONST));
    shr_c   = SW'(sum_c >>> FRAC_BITS);
    pos_c   = ~shr_c[SW-1];
    sat_c_o = (shr_c[SW-1:W-1] != {(SW - W + 1){shr_c[SW-1]}});
    if (sat_c_o) begin
      z_c_o = pos_c ? {1'b0, {(W - 1){1'b1}}} : {1'b1, {(W - 1){1'b0}}};
    end else begin
      z_c_o = shr_c[W-1:0];
    end
  end

endmodule

// File: rtl/dinv_scale.sv
// Stores an N-entry reciprocal diagonal, then scales streamed vectors element-wise
// through a two-stage multiply / round-saturate pipeline.
module dinv_scale
  import dinv_scale_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 16
) (
  input logic        clk,
  input logic        rst,
  dinv_scale_if.slave bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = 2 * W + 1;

  state_e               state_q;
  logic [W-1:0]         dinv_q [N];
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        k_q;
  logic                 s1_valid_q;
  logic                 s1_last_q;
  logic signed [PW-1:0] s1_prod_q;
  logic [W-1:0]         z_out_q;
  logic                 z_valid_q;
  logic                 z_last_q;
  logic                 sat_q;

  logic                 adv_c;
  logic                 y_fire_c;
  logic                 d_fire_c;
  logic signed [PW-1:0] d_sx_c;
  logic signed [PW-1:0] y_sx_c;
  logic signed [PW-1:0] prod_d;
  logic [W-1:0]         z_rs_c;
  logic                 sat_rs_c;

  // Reload takes priority: a coincident d_flag or y transfer has no effect.
  assign adv_c    = ~z_valid_q | bus.z_ready;
  assign y_fire_c = (state_q == ST_SCALE) & bus.en & adv_c & bus.y_valid & ~bus.reload;
  assign d_fire_c = (state_q == ST_LOAD) & bus.en & bus.d_flag & ~bus.reload;

  // Diagonal entry is unsigned, so it is zero-extended before the signed multiply.
  assign d_sx_c = PW'($signed({1'b0, dinv_q[k_q]}));
  assign y_sx_c = PW'($signed(bus.y_in));
  assign prod_d = d_sx_c * y_sx_c;

  q412_round_sat #(.W(W)) u_round_sat (
    .prod_i  (s1_prod_q),
    .z_c_o   (z_rs_c),
    .sat_c_o (sat_rs_c)
  );

  always_ff @(posedge clk) begin
    if (d_fire_c) begin
      dinv_q[idx_q] <= bus.d_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      k_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_prod_q  <= '0;
      z_out_q    <= '0;
      z_valid_q  <= 1'b0;
      z_last_q   <= 1'b0;
      sat_q      <= 1'b0;
    end else if (bus.en) begin
      if (bus.reload) begin
        state_q    <= ST_LOAD;
        idx_q      <= '0;
        k_q        <= '0;
        s1_valid_q <= 1'b0;
        z_valid_q  <= 1'b0;
        sat_q      <= 1'b0;
      end else begin
        if (d_fire_c) begin
          if (idx_q == IW'(N - 1)) begin
            idx_q   <= '0;
            state_q <= ST_SCALE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        // Both stages move together only when the output slot is free.
        if (adv_c) begin
          s1_valid_q <= y_fire_c;
          if (y_fire_c) begin
            s1_prod_q <= prod_d;
            s1_last_q <= (k_q == IW'(N - 1));
            k_q       <= (k_q == IW'(N - 1)) ? '0 : k_q + IW'(1);
          end
          z_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            z_out_q  <= z_rs_c;
            z_last_q <= s1_last_q;
            if (sat_rs_c) begin
              sat_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.y_ready   = (state_q == ST_SCALE) & bus.en & adv_c;
  assign bus.z_out     = z_out_q;
  assign bus.z_valid   = z_valid_q;
  assign bus.z_last    = z_last_q;
  assign bus.load_done = (state_q == ST_SCALE);
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_dinv_scale.sv
// Directed bench for dinv_scale: vector table plus stall, reload and reset sequences.
module tb_dinv_scale;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  dinv_scale_if #(.W(16)) bus ();

  dinv_scale #(.N(8), .W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] d;
    logic [15:0] y;
    logic [15:0] z;
    logic        sat;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reload();
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
  endtask

  task automatic load_const(input logic [15:0] d, input int cnt);
    bus.d_flag = 1'b1;
    bus.d_in   = d;
    repeat (cnt) tick();
    bus.d_flag = 1'b0;
  endtask

  // Reference: exact product, +0.5 LSB, floor, clamp to signed 16 bit.
  function automatic logic [15:0] model(input logic [15:0] d, input logic [15:0] y);
    longint p;
    p = longint'(d) * longint'($signed(y));
    p = (p + 2048) >>> 12;
    if (p > 32767) return 16'h7FFF;
    if (p < -32768) return 16'h8000;
    return 16'(p);
  endfunction

  logic [15:0] sd [8];
  logic [15:0] ys [16];
  logic [15:0] ex [16];

  initial begin
    int sent;
    int recv;
    int first_acc;
    int first_seen;

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.en = 1'b1;
    bus.reload = 1'b0;
    bus.d_in = '0;
    bus.d_flag = 1'b0;
    bus.y_in = '0;
    bus.y_valid = 1'b0;
    bus.z_ready = 1'b1;

    vt[0]  = '{16'h0800, 16'h1000, 16'h0800, 1'b0};
    vt[1]  = '{16'h2000, 16'hF000, 16'hE000, 1'b0};
    vt[2]  = '{16'h0001, 16'h0800, 16'h0001, 1'b0};
    vt[3]  = '{16'h7FFF, 16'h7000, 16'h7FFF, 1'b1};
    vt[4]  = '{16'h7FFF, 16'h9000, 16'h8000, 1'b1};
    vt[5]  = '{16'h0000, 16'h7FFF, 16'h0000, 1'b0};
    vt[6]  = '{16'hFFFF, 16'h0001, 16'h0010, 1'b0};
    vt[7]  = '{16'h1000, 16'h8000, 16'h8000, 1'b0};
    vt[8]  = '{16'h0800, 16'hFFFF, 16'h0000, 1'b0};
    vt[9]  = '{16'h0800, 16'h0001, 16'h0001, 1'b0};
    vt[10] = '{16'h1000, 16'hFFFF, 16'hFFFF, 1'b0};

    // Reset state
    tick();
    chk("rst_z_out", 32'(bus.z_out), 32'h0);
    chk("rst_z_valid", 32'(bus.z_valid), 32'h0);
    chk("rst_z_last", 32'(bus.z_last), 32'h0);
    chk("rst_y_ready", 32'(bus.y_ready), 32'h0);
    chk("rst_load_done", 32'(bus.load_done), 32'h0);
    chk("rst_sat", 32'(bus.sat_flag), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Single-element vectors from the table
    for (int i = 0; i < 11; i++) begin
      do_reload();
      chk($sformatf("v%0d_reload_done", i), 32'(bus.load_done), 32'h0);
      chk($sformatf("v%0d_reload_sat", i), 32'(bus.sat_flag), 32'h0);
      load_const(vt[i].d, 8);
      chk($sformatf("v%0d_load_done", i), 32'(bus.load_done), 32'h1);
      bus.y_valid = 1'b1;
      bus.y_in = vt[i].y;
      chk($sformatf("v%0d_y_ready", i), 32'(bus.y_ready), 32'h1);
      tick();
      bus.y_valid = 1'b0;
      chk($sformatf("v%0d_early_valid", i), 32'(bus.z_valid), 32'h0);
      tick();
      chk($sformatf("v%0d_z_valid", i), 32'(bus.z_valid), 32'h1);
      chk($sformatf("v%0d_z_out", i), 32'(bus.z_out), 32'(vt[i].z));
      chk($sformatf("v%0d_z_last", i), 32'(bus.z_last), 32'h0);
      chk($sformatf("v%0d_sat", i), 32'(bus.sat_flag), 32'(vt[i].sat));
      tick();
    end

    // Two back-to-back vectors with a 5-cycle output stall
    for (int k = 0; k < 8; k++) sd[k] = 16'(32'h0400 * (k + 1));
    for (int j = 0; j < 16; j++) begin
      ys[j] = 16'((j % 2 == 1) ? -(256 * (j + 1)) : (256 * (j + 1)));
      ex[j] = model(sd[j % 8], ys[j]);
    end
    do_reload();
    bus.d_flag = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.d_in = sd[k];
      tick();
    end
    bus.d_flag = 1'b0;
    sent = 0;
    recv = 0;
    first_acc = -1;
    first_seen = -1;
    for (int cyc = 0; cyc < 200 && recv < 16; cyc++) begin
      bus.y_valid = (sent < 16);
      bus.y_in = ys[(sent < 16) ? sent : 0];
      bus.z_ready = !(cyc >= 6 && cyc < 11);
      @(negedge clk);
      if (bus.z_valid) begin
        if (first_seen < 0) first_seen = cyc;
        chk($sformatf("strm_z_out_%0d", recv), 32'(bus.z_out), 32'(ex[recv]));
        chk($sformatf("strm_z_last_%0d", recv), 32'(bus.z_last), 32'(recv % 8 == 7));
        if (bus.z_ready) recv++;
      end
      if (bus.y_valid && bus.y_ready) begin
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      tick();
    end
    bus.y_valid = 1'b0;
    bus.z_ready = 1'b1;
    chk("strm_recv_count", 32'(recv), 32'd16);
    chk("strm_sent_count", 32'(sent), 32'd16);
    chk("strm_latency", 32'(first_seen - first_acc), 32'd2);
    tick();
    tick();
    chk("strm_no_extra", 32'(bus.z_valid), 32'h0);

    // Reload coinciding with d_flag and a y transfer, pipeline full and sat set
    do_reload();
    load_const(16'h7FFF, 8);
    bus.y_valid = 1'b1;
    bus.y_in = 16'h7000;
    tick();
    tick();
    chk("rl_pre_z_valid", 32'(bus.z_valid), 32'h1);
    chk("rl_pre_sat", 32'(bus.sat_flag), 32'h1);
    bus.reload = 1'b1;
    bus.d_flag = 1'b1;
    bus.d_in = 16'h1234;
    chk("rl_y_ready", 32'(bus.y_ready), 32'h1);
    tick();
    bus.reload = 1'b0;
    bus.d_flag = 1'b0;
    bus.y_valid = 1'b0;
    chk("rl_load_done", 32'(bus.load_done), 32'h0);
    chk("rl_z_valid", 32'(bus.z_valid), 32'h0);
    chk("rl_sat", 32'(bus.sat_flag), 32'h0);
    chk("rl_y_ready_after", 32'(bus.y_ready), 32'h0);
    tick();
    chk("rl_s1_flushed", 32'(bus.z_valid), 32'h0);
    load_const(16'h1000, 7);
    chk("rl_seven_loaded", 32'(bus.load_done), 32'h0);
    load_const(16'h1000, 1);
    chk("rl_eight_loaded", 32'(bus.load_done), 32'h1);
    bus.y_valid = 1'b1;
    bus.y_in = 16'h0800;
    tick();
    bus.y_valid = 1'b0;
    tick();
    chk("rl_new_z_valid", 32'(bus.z_valid), 32'h1);
    chk("rl_new_z_out", 32'(bus.z_out), 32'h0800);
    tick();

    // Asynchronous reset mid-vector with data in flight
    do_reload();
    load_const(16'h1000, 8);
    bus.z_ready = 1'b0;
    bus.y_valid = 1'b1;
    bus.y_in = 16'h0300;
    tick();
    bus.y_in = 16'h0400;
    tick();
    chk("ar_pre_z_valid", 32'(bus.z_valid), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_z_out", 32'(bus.z_out), 32'h0);
    chk("ar_z_valid", 32'(bus.z_valid), 32'h0);
    chk("ar_z_last", 32'(bus.z_last), 32'h0);
    chk("ar_y_ready", 32'(bus.y_ready), 32'h0);
    chk("ar_load_done", 32'(bus.load_done), 32'h0);
    chk("ar_sat", 32'(bus.sat_flag), 32'h0);
    bus.z_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("ar_post_y_ready", 32'(bus.y_ready), 32'h0);
    chk("ar_post_z_valid", 32'(bus.z_valid), 32'h0);
    bus.d_flag = 1'b1;
    bus.d_in = 16'h2000;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ar_load%0d_y_ready", i), 32'(bus.y_ready), 32'h0);
      tick();
    end
    bus.d_flag = 1'b0;
    bus.y_in = 16'h0800;
    chk("ar_reloaded_done", 32'(bus.load_done), 32'h1);
    chk("ar_reloaded_y_ready", 32'(bus.y_ready), 32'h1);
    tick();
    bus.y_valid = 1'b0;
    tick();
    chk("ar_new_z_valid", 32'(bus.z_valid), 32'h1);
    chk("ar_new_z_out", 32'(bus.z_out), 32'h1000);
    chk("ar_new_z_last", 32'(bus.z_last), 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dinv_scale.md
DINV_SCALE -- requirements
Module: dinv_scale

Interface
REQ-001 Parameter N, default 8, meaning diagonal length (elements per vector), range 2..64.
REQ-002 Parameter W, default 16, meaning data width of all samples.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-005 en  input  1  global enable; 0 freezes all registers except reset.
REQ-006 d_in  input  16  reciprocal D^-1 element, unsigned Q4.12, from the diagonal-inverse stage.
REQ-007 d_flag  input  1  d_in valid this cycle.
REQ-008 reload  input  1  single-cycle pulse; discard stored diagonal and restart loading.
REQ-009 y_in  input  16  vector element, signed Q4.12.
REQ-010 y_valid / y_ready  input / output  1 each  y handshake; transfer when both are 1.
REQ-011 z_out  output  16  scaled element, signed Q4.12.
REQ-012 z_valid / z_ready  output / input  1 each  z handshake; transfer when both are 1.
REQ-013 z_last  output  1  marks z_out of element index N-1.
REQ-014 load_done  output  1  high while N diagonal entries are held (state SCALE).
REQ-015 sat_flag  output  1  sticky; set when any output saturated, cleared by reset or reload.

Function
REQ-016 FSM states LOAD, SCALE; after reset state = LOAD, write index = 0.
REQ-017 LOAD: each cycle with en and d_flag stores d_in at dinv[idx], idx+1; the write of idx N-1 moves to SCALE next cycle, idx wraps to 0.
REQ-018 LOAD: y_ready = 0; d_flag ignored in SCALE.
REQ-019 SCALE: y_ready = en AND adv, where adv = NOT z_valid OR z_ready.
REQ-020 Accepted y with element counter k: stage 1 registers signed product of {1'b0,dinv[k]} (17b) and y_in (16b) into 33b; k increments, wraps N-1 -> 0.
REQ-021 Stage 2: add 2048 (round half up), arithmetic shift right 12, saturate to [-32768, 32767], register to z_out; last flag travels with data.
REQ-022 Latency: z_valid asserts 2 cycles after the accepting edge when no backpressure; throughput 1 element/cycle.
REQ-023 Pipeline advances only when adv = 1; while z_valid = 1 and z_ready = 0, z_out, z_last and stage 1 hold unchanged; no element lost or duplicated.
REQ-024 Vectors repeat back-to-back indefinitely in SCALE with the same diagonal.
REQ-025 reload (any state, en = 1): next state LOAD, idx = 0, k = 0, both pipeline valids cleared, sat_flag cleared; reload wins over a simultaneous d_flag or y transfer in that cycle.
REQ-026 d_in = 0 is stored without error and yields z = 0.

Reset
REQ-027 Reset values: z_out = 0, z_valid = 0, z_last = 0, y_ready = 0, load_done = 0, sat_flag = 0, state LOAD, idx = 0, k = 0, stage-1 valid = 0; dinv contents need no reset.
REQ-028 Reset mid-vector discards all in-flight elements; after release, a full N-entry reload is required before any output.

Structure
REQ-029 Shared package holds the FSM state encoding, the Q4.12 fraction-bit constant (12) and the rounding constant (2048).
REQ-030 One sub-module, q412_round_sat (33b in -> 16b out, round plus saturation), is used by stage 2; the remainder stays flat.

Verification
REQ-031 Load N = 8 of 0x0800 (0.5); y = 0x1000 -> z = 0x0800, 2 cycles latency, z_last on 8th.
REQ-032 d = 0x2000 (2.0), y = 0xF000 (-1.0) -> z = 0xE000; d = 0x0001, y = 0x0800 -> z = 0x0001 (round up).
REQ-033 d = 0x7FFF, y = 0x7000 -> z = 0x7FFF and sat_flag = 1; y = 0x9000 -> z = 0x8000.
REQ-034 Stream 16 elements with z_ready low for 5 cycles mid-stream -> 16 outputs in order, values held while stalled.
REQ-035 reload in the same cycle as d_flag and a y transfer -> state LOAD, z_valid = 0 next cycle, sat_flag = 0.
REQ-036 rst low for one cycle mid-vector -> all outputs 0 immediately; y_ready stays 0 until 8 new d_flag samples are loaded.
